// File: rtl/regfile_sb_pkg.sv
// ============================================================================
// Module  : regfile_sb_pkg
// Brief   : Shared defaults, register index constants and scoreboard op type
//           for the attopu register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_sb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NRD   = 2;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  typedef enum logic [1:0] {
    SB_HOLD = 2'd0,
    SB_SET  = 2'd1,
    SB_CLR  = 2'd2
  } sb_op_e;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : Per-register busy bits (reserve beats writeback) and the sticky
//           write-to-unreserved-register flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_sel,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_sel,
  output logic [DEPTH-1:0] busy_vec,
  output logic          wr_unrsv
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             r_unrsv;
  logic             w_wr_zero;
  logic             w_unrsv_hit;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_bit
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
        assign w_busy_nxt[i] = 1'b0;
      end else begin : g_live
        sb_op_e w_op;
        // A new producer outranks a writeback from an older one.
        always_comb begin
          w_op = SB_HOLD;
          if (rsv_en && (rsv_sel == AW'(i)))
            w_op = SB_SET;
          else if (wr_en && (wr_sel == AW'(i)))
            w_op = SB_CLR;
        end
        assign w_busy_nxt[i] = (w_op == SB_SET) || ((w_op == SB_HOLD) && r_busy[i]);
      end
    end
  endgenerate

  assign w_wr_zero   = (ZERO_REG != 0) && (wr_sel == '0);
  assign w_unrsv_hit = wr_en && !r_busy[wr_sel] && !w_wr_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_unrsv <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_unrsv <= r_unrsv || w_unrsv_hit;
    end
  end

  assign busy_vec = r_busy;
  assign wr_unrsv = r_unrsv;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module  : regfile_sb
// Brief   : Multi-port register file with busy scoreboard for RAW stalls.
//           Optional macro REGFILE_BYPASS_EN forwards writeback data to reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int NRD      = DEF_NRD,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_sel,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_sel,
  input  logic [NRD*AW-1:0]    rd_sel,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [DEPTH-1:0]     busy_vec,
  output logic                 wr_unrsv
);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic             w_wr_zero;

  assign w_wr_zero = (ZERO_REG != 0) && (wr_sel == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_regs[i] <= '0;
    end else if (wr_en && !w_wr_zero) begin
      r_regs[wr_sel] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .rsv_en   (rsv_en),
    .rsv_sel  (rsv_sel),
    .busy_vec (busy_vec),
    .wr_unrsv (wr_unrsv)
  );

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]    w_sel;
      logic             w_zero;
      logic [WIDTH-1:0] w_data;
      logic             w_busy;

      assign w_sel  = rd_sel[k*AW +: AW];
      assign w_zero = (ZERO_REG != 0) && (w_sel == '0);

      always_comb begin
        w_data = w_zero ? '0 : r_regs[w_sel];
        w_busy = busy_vec[w_sel];
`ifdef REGFILE_BYPASS_EN
        // Forwarded value is only stale if the same edge re-reserves it.
        if (wr_en && (w_sel == wr_sel) && !w_zero) begin
          w_data = wr_data;
          w_busy = rsv_en && (rsv_sel == wr_sel);
        end
`endif
      end

      assign rd_data[k*WIDTH +: WIDTH] = w_data;
      assign rd_busy[k]                = w_busy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module  : tb_regfile_sb
// Brief   : Scoreboard bench for regfile_sb, ZERO_REG=0 and ZERO_REG=1 copies
//           driven in parallel against an array-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;
  import regfile_sb_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [1:0]  rsv_sel = '0;
  logic [3:0]  rd_sel = '0;

  logic [31:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [3:0]  busy_vec0, busy_vec1;
  logic        wr_unrsv0, wr_unrsv1;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(16), .DEPTH(4), .NRD(2), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rd_sel(rd_sel), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .busy_vec(busy_vec0), .wr_unrsv(wr_unrsv0)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(4), .NRD(2), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rd_sel(rd_sel), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .busy_vec(busy_vec1), .wr_unrsv(wr_unrsv1)
  );

  typedef struct packed {
    logic [31:0] d0, d1;
    logic [1:0]  b0, b1;
    logic [3:0]  v0, v1;
    logic        u0, u1;
  } exp_t;

  exp_t exp_q [$];

  // Reference model: index 0 = ZERO_REG=0 copy, 1 = ZERO_REG=1 copy
  int unsigned m_regs [2][4];
  bit          m_busy [2][4];
  bit          m_unrsv [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 4; r++) begin
        m_regs[d][r] = 0;
        m_busy[d][r] = 0;
      end
      m_unrsv[d] = 0;
    end
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    logic [31:0] dat [2];
    logic [1:0]  bsy [2];
    logic [3:0]  vec [2];
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        int s;
        s = (k == 0) ? int'(rd_sel[1:0]) : int'(rd_sel[3:2]);
        if (d == 1 && s == 0) begin
          dat[d][k*16 +: 16] = 16'h0;
          bsy[d][k] = 1'b0;
        end else if (BYP && wr_en && s == int'(wr_sel)) begin
          dat[d][k*16 +: 16] = wr_data;
          bsy[d][k] = rsv_en && (rsv_sel == wr_sel);
        end else begin
          dat[d][k*16 +: 16] = m_regs[d][s][15:0];
          bsy[d][k] = m_busy[d][s];
        end
      end
      for (int r = 0; r < 4; r++) vec[d][r] = m_busy[d][r];
    end
    e.d0 = dat[0]; e.d1 = dat[1];
    e.b0 = bsy[0]; e.b1 = bsy[1];
    e.v0 = vec[0]; e.v1 = vec[1];
    e.u0 = m_unrsv[0]; e.u1 = m_unrsv[1];
    return e;
  endfunction

  // Effect of one clock edge: writeback frees, then a same-edge reserve re-marks.
  function automatic void model_edge();
    for (int d = 0; d < 2; d++) begin
      if (wr_en && !(d == 1 && wr_sel == 2'd0)) begin
        if (!m_busy[d][wr_sel]) m_unrsv[d] = 1;
        m_regs[d][wr_sel] = wr_data;
        m_busy[d][wr_sel] = 0;
      end
      if (rsv_en && !(d == 1 && rsv_sel == 2'd0)) m_busy[d][rsv_sel] = 1;
    end
  endfunction

  task automatic cycle(input bit we, input logic [1:0] ws, input logic [15:0] wd,
                       input bit re, input logic [1:0] rs,
                       input logic [1:0] r0, input logic [1:0] r1);
    @(posedge clk);
    #1;
    wr_en = we; wr_sel = ws; wr_data = wd;
    rsv_en = re; rsv_sel = rs;
    rd_sel = {r1, r0};
    exp_q.push_back(model_expect());
    model_edge();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wr_en = 1'b0; rsv_en = 1'b0;
    model_reset();
    exp_q.push_back(model_expect());
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: the read side is always presenting, so compare every negedge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rd_data_z0",  rd_data0,          e.d0);
      check("rd_busy_z0",  32'(rd_busy0),     32'(e.b0));
      check("busy_vec_z0", 32'(busy_vec0),    32'(e.v0));
      check("wr_unrsv_z0", 32'(wr_unrsv0),    32'(e.u0));
      check("rd_data_z1",  rd_data1,          e.d1);
      check("rd_busy_z1",  32'(rd_busy1),     32'(e.b1));
      check("busy_vec_z1", 32'(busy_vec1),    32'(e.v1));
      check("wr_unrsv_z1", 32'(wr_unrsv1),    32'(e.u1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // reserve R2, write back BEEF, then observe
    cycle(0, R0, 16'h0,    1, R2, R2, R0);
    cycle(1, R2, 16'hBEEF, 0, R0, R2, R0);
    cycle(0, R0, 16'h0,    0, R0, R2, R2);

    // simultaneous reserve and write of R1
    cycle(1, R1, 16'h1234, 1, R1, R1, R2);
    cycle(0, R0, 16'h0,    0, R0, R1, R1);

    // unreserved write sets the sticky flag
    do_reset();
    cycle(1, R3, 16'h00AA, 0, R0, R3, R0);
    cycle(0, R0, 16'h0,    0, R0, R3, R3);
    cycle(0, R0, 16'h0,    0, R0, R0, R0);

    // write/read same register, same cycle
    cycle(1, R1, 16'h5A5A, 0, R0, R0, R1);
    cycle(0, R0, 16'h0,    0, R0, R0, R1);
    // bypass while the same edge re-reserves
    cycle(1, R1, 16'h7777, 1, R1, R1, R0);
    cycle(0, R0, 16'h0,    0, R0, R1, R1);

    // zero register: reserve and write R0
    cycle(1, R0, 16'hFFFF, 1, R0, R0, R0);
    cycle(0, R0, 16'h0,    0, R0, R0, R0);

    // writes then asynchronous reset mid-cycle
    cycle(1, R2, 16'hCAFE, 1, R3, R2, R3);
    cycle(1, R3, 16'hD00D, 0, R0, R2, R3);
    do_reset();
    cycle(0, R0, 16'h0,    0, R0, R2, R3);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 2'($urandom),
              2'($urandom), 2'($urandom));
      end
    end

    @(posedge clk);
    #1;
    wr_en = 1'b0; rsv_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
